joystick_beep_ctrl: RTL and testbench

Input-conditioning stage between the raw joystick left/right switch pins and the buzzer tone generator. It synchronises and debounces both directions and detects press edges. It then stretches each press into a fixed-length beep request on `joystick_left` / `joystick_right`, which feed the tone generator's direction inputs directly. It also exports debounced levels and one-cycle press strobes for the game logic.

---
 rtl/joystick_beep_ctrl.sv | 148 ++++++++++++++
 tb/tb_joystick_beep_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/joystick_beep_ctrl.sv
// Joystick left/right conditioner: 2-flop sync, debounce, press strobe, fixed-length beep request.
// Latency: sw after E(1+DEBOUNCE_CYCLES), press +1, beep/busy +1; no backpressure (free-running outputs).
module joystick_beep_ctrl #(
    parameter int DEBOUNCE_CYCLES = 500_000,
    parameter int BEEP_CYCLES     = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic joy_left_raw,
    input  logic joy_right_raw,
    output logic sw_left,
    output logic sw_right,
    output logic press_left,
    output logic press_right,
    output logic joystick_left,
    output logic joystick_right,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int TW = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] BEEP_LOAD = TW'(BEEP_CYCLES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BEEP = 1'b1
    } state_t;

    // Channel vectors are ordered {left, right}.
    logic [1:0] raw;
    logic [1:0] sync1;
    logic [1:0] sync2;
    logic [1:0] stable;
    logic [1:0] stable_d;
    logic [1:0] press;

    state_t     state;
    state_t     state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic [1:0] dir;
    logic [1:0] dir_nxt;
    logic [1:0] joy_q;
    logic       busy_q;

    assign raw = {joy_left_raw, joy_right_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 2'b00;
            sync2 <= 2'b00;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    for (genvar c = 0; c < 2; c++) begin : g_db
        logic [CW-1:0] cnt;
        logic          stab;

        // Counter only runs while the input disagrees, so it saturates at DB_LAST by flipping.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt  <= '0;
                stab <= 1'b0;
            end else if (sync2[c] == stab) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                stab <= sync2[c];
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stable[c] = stab;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= 2'b00;
            press    <= 2'b00;
        end else begin
            stable_d <= stable;
            press    <= stable & ~stable_d;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        dir_nxt   = dir;
        case (state)
            IDLE: begin
                if (|press) begin
                    state_nxt = BEEP;
                    timer_nxt = BEEP_LOAD;
                    dir_nxt   = press;
                end
            end
            BEEP: begin
                // A new press restarts the request and replaces the direction set.
                if (|press) begin
                    timer_nxt = BEEP_LOAD;
                    dir_nxt   = press;
                end else if (timer != '0) begin
                    timer_nxt = timer - 1'b1;
                end else begin
                    state_nxt = IDLE;
                    dir_nxt   = 2'b00;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                dir_nxt   = 2'b00;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they track the state register exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            timer  <= '0;
            dir    <= 2'b00;
            joy_q  <= 2'b00;
            busy_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            dir    <= dir_nxt;
            joy_q  <= dir_nxt & {2{state_nxt == BEEP}};
            busy_q <= (state_nxt == BEEP);
        end
    end

    assign sw_left        = stable[1];
    assign sw_right       = stable[0];
    assign press_left     = press[1];
    assign press_right    = press[0];
    assign joystick_left  = joy_q[1];
    assign joystick_right = joy_q[0];
    assign busy           = busy_q;

endmodule

// File: tb/tb_joystick_beep_ctrl.sv
// Scoreboard bench for joystick_beep_ctrl: a driver predicts outputs per edge, a monitor compares on the falling edge.
module tb_joystick_beep_ctrl;

    localparam int DEB  = 4;
    localparam int BEEP = 10;

    logic clk = 1'b0;
    logic rst;
    logic joy_left_raw;
    logic joy_right_raw;
    logic sw_left, sw_right, press_left, press_right;
    logic joystick_left, joystick_right, busy;

    int checks = 0;
    int errors = 0;

    logic [6:0] sb_q[$];

    // Reference state: levels as {left, right}; beep modelled by the absolute edge at which it ends.
    logic [1:0] m_s1 = 2'b00;
    logic [1:0] m_s2 = 2'b00;
    logic [1:0] m_prev = 2'b00;
    logic [1:0] m_stable = 2'b00;
    logic [1:0] m_stable_d = 2'b00;
    logic [1:0] m_press = 2'b00;
    logic [1:0] m_dir = 2'b00;
    int         m_run[2] = '{0, 0};
    int         m_end = 0;
    int         edge_no = 0;

    joystick_beep_ctrl #(
        .DEBOUNCE_CYCLES(DEB),
        .BEEP_CYCLES    (BEEP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .joy_left_raw  (joy_left_raw),
        .joy_right_raw (joy_right_raw),
        .sw_left       (sw_left),
        .sw_right      (sw_right),
        .press_left    (press_left),
        .press_right   (press_right),
        .joystick_left (joystick_left),
        .joystick_right(joystick_right),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] dut_outputs();
        return {sw_left, sw_right, press_left, press_right, joystick_left, joystick_right, busy};
    endfunction

    // A level becomes the debounced state once it has been seen DEB consecutive times after syncing.
    task automatic model_step();
        logic [1:0] raw;
        logic [1:0] nxt_press;
        logic       bz;
        raw = {joy_left_raw, joy_right_raw};
        edge_no++;
        if (rst) begin
            m_s1 = 2'b00; m_s2 = 2'b00; m_prev = 2'b00;
            m_stable = 2'b00; m_stable_d = 2'b00; m_press = 2'b00; m_dir = 2'b00;
            m_run[0] = 0; m_run[1] = 0;
            m_end = edge_no;
        end else begin
            if (m_press != 2'b00) begin
                m_dir = m_press;
                m_end = edge_no + BEEP;
            end
            nxt_press  = m_stable & ~m_stable_d;
            m_stable_d = m_stable;
            for (int c = 0; c < 2; c++) begin
                if (m_s2[c] == m_prev[c]) m_run[c] = m_run[c] + 1;
                else m_run[c] = 1;
                m_prev[c] = m_s2[c];
                if (m_s2[c] != m_stable[c] && m_run[c] >= DEB) m_stable[c] = m_s2[c];
            end
            m_s2    = m_s1;
            m_s1    = raw;
            m_press = nxt_press;
        end
        bz = (edge_no < m_end);
        sb_q.push_back({m_stable[1], m_stable[0], m_press[1], m_press[0],
                        bz & m_dir[1], bz & m_dir[0], bz});
    endtask

    task automatic step_cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input logic l, input logic r, input int n);
        joy_left_raw  = l;
        joy_right_raw = r;
        repeat (n) step_cycle();
    endtask

    task automatic pulse_reset(input int n);
        logic [6:0] got;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        got = dut_outputs();
        checks++;
        if (got !== 7'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", got, 7'b0);
        end
        repeat (n) step_cycle();
        rst = 1'b0;
    endtask

    initial begin : monitor
        logic [6:0] exp;
        logic [6:0] got;
        int idx;
        idx = 0;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                exp = sb_q.pop_front();
                got = dut_outputs();
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL outputs[%0d] {swL,swR,prL,prR,joyL,joyR,busy} got=%b exp=%b",
                             idx, got, exp);
                end
                idx++;
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: stimulus did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        rst           = 1'b1;
        joy_left_raw  = 1'b0;
        joy_right_raw = 1'b0;
        repeat (3) step_cycle();
        rst = 1'b0;
        drive(1'b0, 1'b0, 5);

        // clean left press and release
        drive(1'b1, 1'b0, 25);
        drive(1'b0, 1'b0, 20);

        // bounce, then steady press
        for (int i = 0; i < 10; i++) drive((i % 2) == 0, 1'b0, 2);
        drive(1'b1, 1'b0, 25);
        drive(1'b0, 1'b0, 20);

        // short glitch on right
        drive(1'b0, 1'b1, 3);
        drive(1'b0, 1'b0, 20);

        // retrigger during a left beep
        drive(1'b1, 1'b0, 4);
        drive(1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 30);
        drive(1'b0, 1'b0, 20);

        // simultaneous press
        drive(1'b1, 1'b1, 25);
        drive(1'b0, 1'b0, 20);

        // right-only press overrides a left beep
        drive(1'b1, 1'b0, 9);
        drive(1'b1, 1'b1, 25);
        drive(1'b0, 1'b0, 20);

        // reset mid-beep with left still held
        drive(1'b1, 1'b0, 10);
        pulse_reset(2);
        drive(1'b1, 1'b0, 25);
        drive(1'b0, 1'b0, 20);

        // random hold lengths around the debounce threshold
        repeat (60) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end
        drive(1'b0, 1'b0, 20);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0 pending entries", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
